// File: rtl/branch_pkg.sv
// branch_pkg: shared definitions for the branch redirect controller.
//   - funct3 encodings of the conditional branches
//   - FSM state encoding (2-bit)
//   - redirect cause encoding
//   - flush counter width
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Wide enough for the largest flush length (15 cycles).
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    BRANCH = 2'd1,
    JUMP   = 2'd2,
    TRAP   = 2'd3
  } cause_t;

endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: combinational branch-taken decision.
// Ports:
//   f3     in  3  funct3 of the branch
//   z      in  1  ALU zero flag (rs1 == rs2)
//   res    in  1  ALU less-than result (signedness chosen by f3 upstream)
//   branch in  1  execute holds a conditional branch this cycle
//   taken  out 1  branch is valid and its condition holds
module branch_cond_eval
  import branch_pkg::*;
(
  input  logic [2:0] f3,
  input  logic       z,
  input  logic       res,
  input  logic       branch,
  output logic       taken
);

  logic cond;

  always_comb begin
    cond = 1'b0;
    case (f3)
      F3_BEQ:           cond = z;
      F3_BNE:           cond = ~z;
      F3_BLT, F3_BLTU:  cond = res;
      F3_BGE, F3_BGEU:  cond = ~res;
      default:          cond = 1'b0;  // 010/011 are not branches
    endcase
  end

  assign taken = branch & cond;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: turns execute-stage control-flow changes (taken
// branches, JAL/JALR, traps) into a redirect handed to fetch over a
// valid/ready handshake, then holds the front-end flush for FLUSH_CYCLES.
// Optional build macro: BRANCH_STATS_EN adds branch/taken/redirect counters.
// Ports:
//   i_clk, i_rst                 clock, async active-high reset
//   i_Branch, i_f3, i_Z, i_Res   conditional branch and ALU flags
//   i_Jump, i_is_jalr            JAL/JALR request
//   i_pc, i_imm, i_rs1           target operands
//   i_trap, i_trap_vector        trap request and handler address
//   i_fetch_ready                fetch accepts the redirect
//   o_pc_valid, o_pc_target      redirect handshake to fetch
//   o_flush, o_stall             front-end kill / execute freeze
//   o_misaligned                 1-cycle pulse on misaligned branch/jump target
//   o_busy                       FSM not idle
//   o_branch_cnt, o_taken_cnt, o_redirect_cnt  (BRANCH_STATS_EN only)
//
// state    | meaning
// IDLE     | waiting for a taken branch, jump or trap
// REDIRECT | target offered to fetch, pipeline stalled and flushed
// FLUSH    | target accepted, flush held for the remaining cycles
module branch_redirect_ctrl
  import branch_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_Branch,
  input  logic            i_Jump,
  input  logic            i_is_jalr,
  input  logic            i_Z,
  input  logic            i_Res,
  input  logic [2:0]      i_f3,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_rs1,
  input  logic            i_trap,
  input  logic [XLEN-1:0] i_trap_vector,
  input  logic            i_fetch_ready,
`ifdef BRANCH_STATS_EN
  output logic [31:0]     o_branch_cnt,
  output logic [31:0]     o_taken_cnt,
  output logic [31:0]     o_redirect_cnt,
`endif
  output logic            o_pc_valid,
  output logic [XLEN-1:0] o_pc_target,
  output logic            o_flush,
  output logic            o_stall,
  output logic            o_misaligned,
  output logic            o_busy
);

  state_t           state;
  logic [CNT_W-1:0] flush_cnt;
  logic             br_taken;
  cause_t           cause;
  logic [XLEN-1:0]  br_target;
  logic [XLEN-1:0]  jalr_sum;
  logic [XLEN-1:0]  req_target;
  logic             req_misaligned;

  branch_cond_eval u_cond (
    .f3     (i_f3),
    .z      (i_Z),
    .res    (i_Res),
    .branch (i_Branch),
    .taken  (br_taken)
  );

  assign br_target = i_pc + i_imm;
  assign jalr_sum  = i_rs1 + i_imm;

  // Priority: trap > jump > taken branch; losers are simply dropped.
  always_comb begin
    cause      = NONE;
    req_target = '0;
    if (i_trap) begin
      cause      = TRAP;
      req_target = i_trap_vector;
    end else if (i_Jump) begin
      cause      = JUMP;
      req_target = i_is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : br_target;
    end else if (br_taken) begin
      cause      = BRANCH;
      req_target = br_target;
    end
  end

  // Trap vectors are trusted; only branch/jump targets are alignment-checked.
  assign req_misaligned = ((cause == JUMP) || (cause == BRANCH)) && req_target[1];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      flush_cnt    <= '0;
      o_pc_target  <= '0;
      o_pc_valid   <= 1'b0;
      o_stall      <= 1'b0;
      o_flush      <= 1'b0;
      o_misaligned <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      o_misaligned <= 1'b0;
      case (state)
        IDLE: begin
          if (cause != NONE) begin
            if (req_misaligned) begin
              o_misaligned <= 1'b1;
            end else begin
              state       <= REDIRECT;
              o_pc_target <= req_target;
              o_pc_valid  <= 1'b1;
              o_stall     <= 1'b1;
              o_flush     <= 1'b1;
              o_busy      <= 1'b1;
            end
          end
        end
        REDIRECT: begin
          // A trap replaces the offered target; if fetch took the old one
          // this same cycle, the trap simply becomes the next redirect.
          if (i_trap) begin
            o_pc_target <= i_trap_vector;
          end else if (i_fetch_ready) begin
            o_pc_valid <= 1'b0;
            o_stall    <= 1'b0;
            if (FLUSH_CYCLES == 1) begin
              state   <= IDLE;
              o_flush <= 1'b0;
              o_busy  <= 1'b0;
            end else begin
              state     <= FLUSH;
              flush_cnt <= CNT_W'(FLUSH_CYCLES - 1);
            end
          end
        end
        FLUSH: begin
          if (i_trap) begin
            state       <= REDIRECT;
            o_pc_target <= i_trap_vector;
            o_pc_valid  <= 1'b1;
            o_stall     <= 1'b1;
          end else if (flush_cnt == '0) begin
            state   <= IDLE;
            o_flush <= 1'b0;
            o_busy  <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          flush_cnt  <= '0;
          o_pc_valid <= 1'b0;
          o_stall    <= 1'b0;
          o_flush    <= 1'b0;
          o_busy     <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_branch_cnt   <= '0;
      o_taken_cnt    <= '0;
      o_redirect_cnt <= '0;
    end else begin
      if ((state == IDLE) && i_Branch)
        o_branch_cnt <= o_branch_cnt + 32'd1;
      if ((state == IDLE) && br_taken && !br_target[1])
        o_taken_cnt <= o_taken_cnt + 32'd1;
      if (o_pc_valid && i_fetch_ready)
        o_redirect_cnt <= o_redirect_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
module tb_branch_redirect_ctrl;

  localparam int XLEN         = 32;
  localparam int FLUSH_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        br = 1'b0, jump = 1'b0, is_jalr = 1'b0, z = 1'b0, res = 1'b0;
  logic [2:0]  f3 = 3'd0;
  logic [31:0] pc = '0, imm = '0, rs1 = '0, trap_vector = '0;
  logic        trap = 1'b0, fetch_ready = 1'b0;
  logic        pc_valid, flush, stall, misaligned, busy;
  logic [31:0] pc_target;
`ifdef BRANCH_STATS_EN
  logic [31:0] branch_cnt, taken_cnt, redirect_cnt;
`endif

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_Branch      (br),
    .i_Jump        (jump),
    .i_is_jalr     (is_jalr),
    .i_Z           (z),
    .i_Res         (res),
    .i_f3          (f3),
    .i_pc          (pc),
    .i_imm         (imm),
    .i_rs1         (rs1),
    .i_trap        (trap),
    .i_trap_vector (trap_vector),
    .i_fetch_ready (fetch_ready),
`ifdef BRANCH_STATS_EN
    .o_branch_cnt  (branch_cnt),
    .o_taken_cnt   (taken_cnt),
    .o_redirect_cnt(redirect_cnt),
`endif
    .o_pc_valid    (pc_valid),
    .o_pc_target   (pc_target),
    .o_flush       (flush),
    .o_stall       (stall),
    .o_misaligned  (misaligned),
    .o_busy        (busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        valid;
    logic        stall;
    logic        flush;
    logic        busy;
    logic        mis;
    logic [31:0] tgt;
  } exp_t;

  exp_t        status_q[$];
  logic [31:0] accept_q[$];

  bit          m_pend;
  logic [31:0] m_tgt;
  int          m_flush_left;
  bit          m_mis;
  int unsigned m_br, m_taken, m_redir;

  function automatic bit cond_holds(logic [2:0] f, logic zf, logic rf);
    case (f)
      3'd0:       return zf;
      3'd1:       return !zf;
      3'd4, 3'd6: return rf;
      3'd5, 3'd7: return !rf;
      default:    return 1'b0;
    endcase
  endfunction

  task automatic model_clear();
    status_q.delete();
    accept_q.delete();
    m_pend = 0; m_tgt = '0; m_flush_left = 0; m_mis = 0;
    m_br = 0; m_taken = 0; m_redir = 0;
  endtask

  task automatic model_step();
    logic [31:0] t, btgt;
    bit          req, bt;
    exp_t        e;
    m_mis = 0;
    if (m_pend) begin
      if (fetch_ready) m_redir++;
      if (trap) begin
        m_tgt = trap_vector;
        if (fetch_ready) accept_q.push_back(m_tgt);
        else if (accept_q.size() > 0) accept_q[accept_q.size()-1] = m_tgt;
      end else if (fetch_ready) begin
        m_pend       = 0;
        m_flush_left = (FLUSH_CYCLES == 1) ? 0 : FLUSH_CYCLES;
      end
    end else if (m_flush_left > 0) begin
      if (trap) begin
        m_pend = 1; m_tgt = trap_vector; m_flush_left = 0;
        accept_q.push_back(m_tgt);
      end else begin
        m_flush_left--;
      end
    end else begin
      req  = 0;
      t    = '0;
      btgt = pc + imm;
      bt   = br && cond_holds(f3, z, res);
      if (br) m_br++;
      if (bt && !btgt[1]) m_taken++;
      if (trap) begin
        req = 1; t = trap_vector;
      end else if (jump) begin
        t = is_jalr ? ((rs1 + imm) & 32'hFFFF_FFFE) : btgt;
        if (t[1]) m_mis = 1; else req = 1;
      end else if (bt) begin
        t = btgt;
        if (t[1]) m_mis = 1; else req = 1;
      end
      if (req) begin
        m_pend = 1; m_tgt = t;
        accept_q.push_back(t);
      end
    end
    e.valid = m_pend;
    e.stall = m_pend;
    e.flush = m_pend || (m_flush_left > 0);
    e.busy  = m_pend || (m_flush_left > 0);
    e.mis   = m_mis;
    e.tgt   = m_tgt;
    status_q.push_back(e);
  endtask

  always @(posedge clk) if (!rst) model_step();

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (status_q.size() > 0) begin
        e = status_q.pop_front();
        chk("pc_valid", pc_valid, e.valid);
        chk("stall", stall, e.stall);
        chk("flush", flush, e.flush);
        chk("busy", busy, e.busy);
        chk("misaligned", misaligned, e.mis);
        if (e.valid) chk("held_target", pc_target, e.tgt);
      end
      if (pc_valid && fetch_ready) begin
        if (accept_q.size() == 0) chk("unexpected_accept", 1'b1, 1'b0);
        else chk("accept_target", pc_target, accept_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    br = 0; jump = 0; is_jalr = 0; trap = 0; z = 0; res = 0; f3 = 3'd0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, pc_valid, 1'b0);
    chk({tag, "_target"}, pc_target, 32'h0);
    chk({tag, "_flush"}, flush, 1'b0);
    chk({tag, "_stall"}, stall, 1'b0);
    chk({tag, "_mis"}, misaligned, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    #1;
    check_all_zero("reset");
    repeat (3) cyc();
    rst = 1'b0;
    model_clear();

    // BEQ taken, fetch ready at once
    br = 1; f3 = 3'd0; z = 1; pc = 32'h100; imm = 32'h20; fetch_ready = 1;
    cyc(); idle_inputs();
    chk("beq_valid", pc_valid, 1'b1);
    chk("beq_target", pc_target, 32'h120);
    cyc();
    chk("beq_flush1", flush, 1'b1);
    chk("beq_flush1_valid", pc_valid, 1'b0);
    cyc();
    chk("beq_flush2", flush, 1'b1);
    cyc();
    chk("beq_done_busy", busy, 1'b0);
    chk("beq_done_flush", flush, 1'b0);

    // not-taken BNE and reserved funct3
    br = 1; f3 = 3'd1; z = 1;
    cyc();
    chk("bne_nt_busy", busy, 1'b0);
    f3 = 3'd2; z = 0; res = 1;
    cyc(); idle_inputs();
    chk("f3_010_busy", busy, 1'b0);
    chk("f3_010_valid", pc_valid, 1'b0);

    // JALR with fetch back-pressure
    jump = 1; is_jalr = 1; rs1 = 32'h2003; imm = 32'h1; fetch_ready = 0;
    cyc(); idle_inputs();
    for (int i = 0; i < 3; i++) begin
      chk("jalr_hold_valid", pc_valid, 1'b1);
      chk("jalr_hold_stall", stall, 1'b1);
      chk("jalr_hold_target", pc_target, 32'h2004);
      if (i == 2) fetch_ready = 1;
      cyc();
    end
    chk("jalr_accepted", pc_valid, 1'b0);
    repeat (2) cyc();

    // trap wins over taken BLT, then a trap during FLUSH
    trap = 1; trap_vector = 32'h80; br = 1; f3 = 3'd4; res = 1;
    pc = 32'h200; imm = 32'h40; fetch_ready = 1;
    cyc(); idle_inputs();
    chk("trap_prio_target", pc_target, 32'h80);
    cyc();
    chk("trap_flush_state", flush && !pc_valid, 1'b1);
    trap = 1; fetch_ready = 0;
    cyc(); trap = 0;
    chk("trap_in_flush_valid", pc_valid, 1'b1);
    chk("trap_in_flush_target", pc_target, 32'h80);
    fetch_ready = 1;
    repeat (3) cyc();

    // misaligned BGE target
    br = 1; f3 = 3'd5; res = 0; pc = 32'h100; imm = 32'h6;
    cyc(); idle_inputs();
    chk("mis_pulse", misaligned, 1'b1);
    chk("mis_no_valid", pc_valid, 1'b0);
    cyc();
    chk("mis_pulse_end", misaligned, 1'b0);

    // asynchronous reset while in REDIRECT
    br = 1; f3 = 3'd0; z = 1; pc = 32'h300; imm = 32'h10; fetch_ready = 0;
    cyc(); idle_inputs();
    chk("pre_reset_valid", pc_valid, 1'b1);
    #1 rst = 1'b1;
    #1 check_all_zero("async_reset");
    model_clear();
    repeat (2) cyc();
    rst = 1'b0;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      br          = ($urandom_range(0, 99) < 30);
      jump        = ($urandom_range(0, 99) < 15);
      is_jalr     = $urandom_range(0, 1);
      trap        = ($urandom_range(0, 99) < 5);
      f3          = 3'($urandom_range(0, 7));
      z           = $urandom_range(0, 1);
      res         = $urandom_range(0, 1);
      pc          = $urandom & 32'hFFFF_FFFC;
      imm         = ($urandom & 32'hFFFF_FFF8) | (($urandom_range(0, 3) == 0) ? 32'h2 : 32'h0) | 32'h4;
      rs1         = $urandom;
      trap_vector = $urandom & 32'hFFFF_FFFC;
      fetch_ready = trap ? 1'b0 : ($urandom_range(0, 99) < 60);
      cyc();
    end
    idle_inputs();
    fetch_ready = 1;
    repeat (10) cyc();
    chk("accept_queue_drained", 64'(accept_q.size()), 64'd0);
    chk("final_idle", busy, 1'b0);
`ifdef BRANCH_STATS_EN
    chk("branch_cnt", branch_cnt, m_br);
    chk("taken_cnt", taken_cnt, m_taken);
    chk("redirect_cnt", redirect_cnt, m_redir);
    #1 rst = 1'b1;
    #1 chk("branch_cnt_rst", branch_cnt, 32'h0);
    chk("redirect_cnt_rst", redirect_cnt, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
Sequences control-flow changes in the core.
- Evaluates conditional branches, JAL/JALR and traps from the execute stage.
- Computes the redirect target and hands it to fetch with a valid/ready handshake.
- Then holds the pipeline flush for a fixed number of cycles.
- Sits between execute/ALU flags and the fetch PC mux; owns o_flush and o_stall for the front end.

Parameters:
XLEN, 32, datapath/PC width
FLUSH_CYCLES, 2, cycles o_flush stays high after redirect acceptance (1..15)

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous active-high reset
i_Branch  in  1  execute holds a conditional branch (valid this cycle)
i_Jump  in  1  execute holds JAL/JALR
i_is_jalr  in  1  qualifies i_Jump: 1=JALR, 0=JAL
i_Z  in  1  ALU zero flag (rs1==rs2)
i_Res  in  1  ALU compare result (signed/unsigned less-than per f3)
i_f3  in  3  funct3 of branch
i_pc  in  XLEN  PC of execute instruction
i_imm  in  XLEN  sign-extended immediate
i_rs1  in  XLEN  rs1 value for JALR
i_trap  in  1  trap request from CSR unit
i_trap_vector  in  XLEN  trap handler address
i_fetch_ready  in  1  fetch accepts redirect
o_pc_valid  out  1  redirect target valid
o_pc_target  out  XLEN  redirect address
o_flush  out  1  kill IF/ID instructions
o_stall  out  1  freeze execute and earlier while redirect pending
o_misaligned  out  1  one-cycle pulse: taken target not 4-byte aligned
o_busy  out  1  FSM not IDLE

Behaviour:
- Reset (async, i_rst=1): state IDLE, all outputs 0, o_pc_target 0, flush counter 0.
- Branch condition (combinational):
  - BEQ 000 taken iff i_Z.
  - BNE 001 iff !i_Z.
  - BLT 100 / BLTU 110 iff i_Res.
  - BGE 101 / BGEU 111 iff !i_Res.
  - 010, 011 never taken.
  - Gated by i_Branch.
- Target rules, XLEN-bit modulo arithmetic, wrap-around ignored:
  - Branch/JAL: i_pc+i_imm.
  - JALR: (i_rs1+i_imm) with bit0 cleared.
  - Trap: i_trap_vector as-is.
- Request priority in IDLE: i_trap > i_Jump > taken branch. Simultaneous requests: lower-priority ones are dropped.
- Misaligned target (bit1 set) on a branch/jump: o_misaligned pulses for 1 cycle, no redirect, stay IDLE. Traps are never checked.
- States:
  - IDLE: on valid request, latch target into o_pc_target, go REDIRECT.
  - REDIRECT: o_pc_valid=1, o_stall=1, o_flush=1. o_pc_target stable until i_fetch_ready. Handshake completes on the cycle o_pc_valid&&i_fetch_ready; then load counter with FLUSH_CYCLES-1 and go FLUSH. If FLUSH_CYCLES==1, go straight to IDLE.
  - FLUSH: o_flush=1, o_stall=0, o_pc_valid=0. Decrement counter each cycle; at 0 go IDLE.
- i_trap in REDIRECT (not yet accepted): retarget to i_trap_vector on next edge, stay REDIRECT.
- i_trap in FLUSH: go REDIRECT with trap target.
- Branch/jump inputs are ignored outside IDLE; the stall guarantees no loss.
- Latency: request in cycle N → o_pc_valid high in N+1. Not-taken branch: zero-cycle effect, no outputs.
- o_busy = (state != IDLE).
- Reset mid-operation: immediate return to IDLE, all outputs 0.

Optional Feature:
BRANCH_STATS_EN
- Defined:
  - Adds outputs o_branch_cnt[31:0], o_taken_cnt[31:0], o_redirect_cnt[31:0], each wrapping modulo 2^32 and cleared by i_rst.
  - o_branch_cnt increments per i_Branch sampled in IDLE.
  - o_taken_cnt increments per taken aligned branch.
  - o_redirect_cnt increments per completed handshake.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package branch_pkg:
  - funct3 constants BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - FSM state enum IDLE/REDIRECT/FLUSH (2-bit).
  - Redirect-cause enum NONE/BRANCH/JUMP/TRAP.
- One combinational sub-module branch_cond_eval: f3, Z, Res, Branch → taken.
- FSM, target muxing and counters stay in branch_redirect_ctrl.

Test Plan:
- BEQ, i_Z=1, i_pc=0x100, i_imm=0x20, i_fetch_ready=1 → next cycle o_pc_valid=1, o_pc_target=0x120. Then o_flush high 2 more cycles (FLUSH), then o_busy=0.
- BNE with i_Z=1, and f3=010 with i_Branch=1 → no outputs asserted, state stays IDLE.
- JALR: i_rs1=0x2003, i_imm=0x1 → target 0x2004. Hold i_fetch_ready=0 for 3 cycles: o_pc_valid, o_stall and target held stable; accept on cycle 4.
- Simultaneous i_trap (vector 0x80) and taken BLT → target 0x80. Then i_trap during FLUSH → returns to REDIRECT with 0x80.
- BGE taken with i_pc=0x100, i_imm=0x6 → o_misaligned 1-cycle pulse, o_pc_valid stays 0.
- Assert i_rst while in REDIRECT → all outputs 0 immediately, asynchronously. With BRANCH_STATS_EN: after 3 branches (2 taken) and 2 redirects, counters read 3/2/2, cleared by reset.
